// File: rtl/branch_redirect_ctrl_if.sv
// Branch-resolution and fetch-redirect signals between EX, the redirect controller and fetch.
// slave = controller view; master = EX/fetch view.
interface branch_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    // Both channels are valid/ready: a transfer happens on a cycle where valid and ready
    // are both high. A valid source holds its payload until then. ready may be asserted
    // before valid; it may also depend on valid.
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_br_taken;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_br_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            redir_ready;

    modport slave (
        input  ex_valid, ex_br_taken, ex_pc, ex_br_target, ex_pred_taken, ex_pred_target,
        input  redir_ready,
        output ex_ready, redir_valid, redir_pc
    );

    modport master (
        output ex_valid, ex_br_taken, ex_pc, ex_br_target, ex_pred_taken, ex_pred_target,
        output redir_ready,
        input  ex_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Mispredict detection and fetch-redirect / pipeline-flush sequencing.
// Optional BR_PERF_CNT_EN adds resolution and mispredict counters.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_redirect_ctrl_if.slave  bus,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic [31:0]            br_cnt,
    output logic [31:0]            mispred_cnt,
    output logic [1:0]             dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LEN = 3'(FLUSH_CYCLES);

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic [XLEN-1:0] redir_pc_q;
    logic            redir_valid_q;
    logic            flush_if_id_q;
    logic            flush_id_ex_q;

    logic            accept;
    logic            mispred;
    logic [XLEN-1:0] correct_pc;

    assign bus.ex_ready = (state_q == S_IDLE);
    assign accept       = bus.ex_valid & bus.ex_ready;
    assign correct_pc   = bus.ex_br_taken ? bus.ex_br_target : bus.ex_pc + XLEN'(4);
    // The predicted target only matters when the branch really was taken.
    assign mispred      = (bus.ex_br_taken != bus.ex_pred_taken) |
                          (bus.ex_br_taken & (bus.ex_br_target != bus.ex_pred_target));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            redir_pc_q    <= '0;
            redir_valid_q <= 1'b0;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && mispred) begin
                        state_q       <= S_REDIRECT;
                        redir_pc_q    <= correct_pc;
                        redir_valid_q <= 1'b1;
                        flush_if_id_q <= 1'b1;
                        flush_id_ex_q <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    if (bus.redir_ready) begin
                        redir_valid_q <= 1'b0;
                        flush_id_ex_q <= 1'b0;
                        if (FLUSH_LEN != 3'd0) begin
                            state_q       <= S_FLUSH;
                            cnt_q         <= FLUSH_LEN;
                            flush_if_id_q <= 1'b1;
                        end else begin
                            state_q       <= S_IDLE;
                            flush_if_id_q <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    // cnt_q holds the FLUSH cycles still to run, including this one.
                    if (cnt_q <= 3'd1) begin
                        state_q       <= S_IDLE;
                        cnt_q         <= '0;
                        flush_if_id_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    cnt_q         <= '0;
                    redir_valid_q <= 1'b0;
                    flush_if_id_q <= 1'b0;
                    flush_id_ex_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.redir_valid = redir_valid_q;
    assign bus.redir_pc    = redir_pc_q;
    assign flush_if_id     = flush_if_id_q;
    assign flush_id_ex     = flush_id_ex_q;
    assign dbg_state       = state_q;

`ifdef BR_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else if (accept) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign br_cnt      = 32'd0;
    assign mispred_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_branch_redirect_ctrl;
  localparam int FC = 1;

  logic        clk;
  logic        rst_n;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  branch_redirect_ctrl_if #(.XLEN(32)) bus ();

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: an outstanding redirect plus a count of flush-only cycles left
  bit          m_redir;
  int          m_tail;
  logic [31:0] m_pc;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  task automatic model_reset();
    m_redir = 0;
    m_tail  = 0;
    m_pc    = 32'd0;
    m_br    = 32'd0;
    m_mis   = 32'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit busy;
    busy = m_redir || (m_tail > 0);
    chk("ex_ready",    {31'd0, bus.ex_ready},    {31'd0, !busy});
    chk("redir_valid", {31'd0, bus.redir_valid}, {31'd0, m_redir});
    chk("flush_id_ex", {31'd0, flush_id_ex},     {31'd0, m_redir});
    chk("flush_if_id", {31'd0, flush_if_id},     {31'd0, busy});
    chk("redir_pc",    bus.redir_pc,             m_pc);
`ifdef BR_PERF_CNT_EN
    chk("br_cnt",      br_cnt,      m_br);
    chk("mispred_cnt", mispred_cnt, m_mis);
`else
    chk("br_cnt",      br_cnt,      32'd0);
    chk("mispred_cnt", mispred_cnt, 32'd0);
`endif
  endtask

  // Called at a falling edge: check current outputs, drive the next cycle, advance the model.
  task automatic step(input bit v, input bit taken, input logic [31:0] pc,
                      input logic [31:0] tgt, input bit ptaken, input logic [31:0] ptgt,
                      input bit rready);
    bit ready_m;
    bit wrong;
    check_all();
    bus.ex_valid       = v;
    bus.ex_br_taken    = taken;
    bus.ex_pc          = pc;
    bus.ex_br_target   = tgt;
    bus.ex_pred_taken  = ptaken;
    bus.ex_pred_target = ptgt;
    bus.redir_ready    = rready;
    ready_m = !m_redir && (m_tail == 0);
    wrong   = (taken != ptaken) || (taken && (tgt != ptgt));
    if (ready_m && v) begin
      m_br++;
      if (wrong) begin
        m_mis++;
        m_redir = 1;
        m_pc    = taken ? tgt : pc + 32'd4;
      end
    end else if (m_redir && rready) begin
      m_redir = 0;
      m_tail  = FC;
    end else if (m_tail > 0) begin
      m_tail--;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rready);
    for (int i = 0; i < n; i++) step(0, 0, 32'd0, 32'd0, 0, 32'd0, rready);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ex_valid = 1'b0;
    bus.redir_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.ex_valid = 0; bus.ex_br_taken = 0; bus.ex_pc = 0; bus.ex_br_target = 0;
    bus.ex_pred_taken = 0; bus.ex_pred_target = 0; bus.redir_ready = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst ex_ready",    {31'd0, bus.ex_ready},    32'd1);
    chk("rst redir_valid", {31'd0, bus.redir_valid}, 32'd0);
    chk("rst redir_pc",    bus.redir_pc,             32'd0);
    chk("rst flush_if_id", {31'd0, flush_if_id},     32'd0);
    chk("rst flush_id_ex", {31'd0, flush_id_ex},     32'd0);
    rst_n = 1'b1;

    // correctly predicted taken branch
    step(1, 1, 32'h100, 32'h200, 1, 32'h200, 0);
    chk("good ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    idle(2, 0);

    // predicted taken, actually not taken
    step(1, 0, 32'h1000, 32'h2000, 1, 32'h2000, 1);
    chk("nt redir_pc",    bus.redir_pc,              32'h1004);
    chk("nt redir_valid", {31'd0, bus.redir_valid},  32'd1);
    step(0, 0, 32'd0, 32'd0, 0, 32'd0, 1);
    chk("nt flush tail",  {30'd0, flush_if_id, flush_id_ex}, 32'b10);
    chk("nt ex_ready lo", {31'd0, bus.ex_ready},     32'd0);
    step(0, 0, 32'd0, 32'd0, 0, 32'd0, 1);
    chk("nt ex_ready hi", {31'd0, bus.ex_ready},     32'd1);
    chk("nt flush done",  {31'd0, flush_if_id},      32'd0);

    // wrong target, fetch stalls the redirect for 3 cycles while EX keeps presenting
    step(1, 1, 32'h50, 32'h300, 1, 32'h280, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall redir_pc", bus.redir_pc, 32'h300);
      step(1, 0, 32'h900 + 32'(i * 4), 32'h0, 1, 32'h0, 0);
    end
    chk("stall redir_pc", bus.redir_pc, 32'h300);
    step(1, 1, 32'h990, 32'h4000, 0, 32'h0, 1);
    idle(2, 0);

    // PC wrap-around
    step(1, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 0);
    chk("wrap redir_pc", bus.redir_pc, 32'h0000_0000);
    step(0, 0, 32'd0, 32'd0, 0, 32'd0, 0);

    // asynchronous reset while a redirect is pending
    check_all();
    #1 rst_n = 1'b0;
    #1;
    chk("async redir_valid", {31'd0, bus.redir_valid}, 32'd0);
    chk("async flush",       {30'd0, flush_if_id, flush_id_ex}, 32'd0);
    chk("async redir_pc",    bus.redir_pc, 32'd0);
    chk("async ex_ready",    {31'd0, bus.ex_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 1);

    // counters: 5 accepts, 2 mispredicts
    do_reset();
    step(1, 1, 32'h10, 32'h40, 1, 32'h40, 1);
    step(1, 1, 32'h20, 32'h80, 0, 32'h0, 1);
    idle(2, 1);
    step(1, 0, 32'h30, 32'h0, 0, 32'h0, 1);
    step(1, 0, 32'h34, 32'h0, 1, 32'h70, 1);
    idle(2, 1);
    step(1, 0, 32'h40, 32'h0, 0, 32'h0, 1);
`ifdef BR_PERF_CNT_EN
    chk("br_cnt total",  br_cnt,      32'd5);
    chk("mispred total", mispred_cnt, 32'd2);
`else
    chk("br_cnt total",  br_cnt,      32'd0);
    chk("mispred total", mispred_cnt, 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      logic [31:0] tgt;
      logic [31:0] ptgt;
      pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      tgt  = ($urandom_range(0, 1) == 1) ? 32'h400 : 32'h800;
      ptgt = ($urandom_range(0, 1) == 1) ? 32'h400 : 32'h800;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, pc, tgt,
           $urandom_range(0, 1) == 1, ptgt, $urandom_range(0, 1) == 1);
    end
    idle(3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences control-flow recovery for the 32-bit RISC-V pipeline. It takes each branch/jump resolution from EX (the taken decision plus computed target), compares it against the fetch-time prediction, and on a mispredict issues a single redirect to fetch over a valid/ready handshake. While recovery is in progress it flushes the younger pipeline stages and back-pressures EX. It sits between the EX-stage branch comparator and the fetch/PC unit.

## Interface
- XLEN, 32, address/data width
- FLUSH_CYCLES, 1, extra cycles `flush_if_id` stays high after redirect handshake (legal 0..7)
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX holds a branch/jump resolution this cycle
- ex_br_taken  input  1  resolved taken (branch condition true or jump)
- ex_pc  input  XLEN  PC of resolving instruction
- ex_br_target  input  XLEN  computed taken target
- ex_pred_taken  input  1  fetch-time predicted taken
- ex_pred_target  input  XLEN  fetch-time predicted target
- ex_ready  output  1  resolution accepted this cycle when `ex_valid` is high
- redir_valid  output  1  redirect request to fetch
- redir_pc  output  XLEN  corrected fetch PC
- redir_ready  input  1  fetch accepts redirect
- flush_if_id  output  1  squash IF/ID register
- flush_id_ex  output  1  squash ID/EX register
- br_cnt  output  32  resolutions accepted (only with macro)
- mispred_cnt  output  32  mispredicts detected (only with macro)

## Operation
- Accept = `ex_valid & ex_ready`. `ex_ready` = 1 only in IDLE, combinationally from state. `ex_valid` while `ex_ready`=0 is ignored; EX holds its instruction.
- Correct PC = `ex_br_taken ? ex_br_target : ex_pc + 4`, mod 2^XLEN (wraps silently).
- Mispredict = `ex_br_taken != ex_pred_taken` OR (`ex_br_taken` AND `ex_br_target != ex_pred_target`). `ex_pred_target` is ignored when not taken.
- Correctly predicted accept: no state change, no outputs.
- States:
  - IDLE: all outputs 0. Mispredicting accept -> REDIRECT, with correct PC registered into `redir_pc`.
  - REDIRECT: `redir_valid`=1, `flush_if_id`=1, `flush_id_ex`=1.
    - `redir_ready`=1 -> FLUSH if FLUSH_CYCLES>0, else IDLE.
    - `redir_ready`=0 -> stay.
  - FLUSH: `flush_if_id`=1, others 0. A down-counter loaded with FLUSH_CYCLES on entry. The state lasts exactly FLUSH_CYCLES cycles, then -> IDLE.
- `redir_pc` is stable while `redir_valid`=1 and holds its last value otherwise. Its reset value is 0.
- Reset (any time, including mid-REDIRECT/FLUSH): state IDLE; all outputs, the down-counter and the counters go to 0. A pending redirect is discarded.

## Timing
- Mispredicting accept in cycle T -> `redir_valid`, both flushes high from T+1.
- Handshake in cycle H (`redir_valid & redir_ready`) -> `redir_valid` and `flush_id_ex` low at H+1.
  - `flush_if_id` stays high through H+FLUSH_CYCLES and is low at H+FLUSH_CYCLES+1.
  - `ex_ready` returns high at H+FLUSH_CYCLES+1.
- `redir_ready` high before `redir_valid` has no effect. `redir_ready` may depend combinationally on `redir_valid`.
- No combinational path from any `ex_*` input to any output except `ex_ready`, which depends on state only.
- Minimum mispredict-to-mispredict spacing: 2+FLUSH_CYCLES cycles.

## Configuration
- `BR_PERF_CNT_EN` defined:
  - `br_cnt` increments on every accept.
  - `mispred_cnt` increments on every mispredicting accept.
  - Both are 32-bit, wrap at 2^32, and update at the clock edge ending the accept cycle.
- Not defined: both ports are tied to 0 and no counter flops are generated.

## Test plan
- Reset values: hold rst_n=0 -> all outputs 0, `ex_ready`=1. Release, then drive a predicted-correct taken branch (pc=0x100, target=0x200, pred_taken=1, pred_target=0x200) -> no redirect, `ex_ready` stays 1.
- Predicted-taken, actually not-taken at pc=0x1000 with `redir_ready`=1, FLUSH_CYCLES=1 -> `redir_pc`=0x1004 for one cycle; `flush_if_id` high 2 cycles, `flush_id_ex` high 1 cycle; `ex_ready` low 2 cycles.
- Taken with target 0x300 but pred_target 0x280 -> redirect to 0x300. Hold `redir_ready`=0 for 3 cycles -> `redir_valid` and `redir_pc` stable for 4 cycles, `ex_valid` ignored throughout.
- Wrap-around: pc=0xFFFFFFFC, not-taken, pred_taken=1 -> `redir_pc`=0x00000000.
- Assert rst_n=0 mid-REDIRECT -> outputs 0 immediately (asynchronously). After release, no redirect reappears.
- With `BR_PERF_CNT_EN`: 5 accepts, 2 of them mispredicts -> `br_cnt`=5, `mispred_cnt`=2. Without the macro, both read 0.
